// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, frame sizing and the
// parity rule used by both the transmitter and the receiver's checker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // start + parity + stop around the data bits
  localparam int FRAME_OVERHEAD = 3;

  function automatic int frame_bits(input int word_length);
    return word_length + FRAME_OVERHEAD;
  endfunction

  // Zero-extending the word does not change its XOR, so one 32-bit function
  // serves every word length up to 32.
  function automatic logic parity_bit(input logic [31:0] data, input logic even);
    return even ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last clk of each
// bit period with bit_end and wraps. clear holds it at zero.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  assign bit_end = (count == CNT_W'(CLKS_PER_BIT - 1));

  // Count up through one bit period, wrapping on the last clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start(0), data LSB first, parity, stop(1), with a
// one-word holding buffer so the next word can follow with no idle gap.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  ST_IDLE   | line high; waits for a word in the holding buffer
//  ST_START  | line low for one bit period
//  ST_DATA   | shifts out WORD_LENGTH bits, LSB first
//  ST_PARITY | line carries the parity computed at load time
//  ST_STOP   | line high; TX_Done on last clk; reloads if a word waits
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EVEN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] DATATX,
  input  logic                   Transmit,
  output logic                   SerialDataOut,
  output logic                   TX_Busy,
  output logic                   TX_Ready,
  output logic                   TX_Done,
  output logic                   TX_Overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  tx_state_t              state;
  logic [WORD_LENGTH-1:0] hold_data;
  logic [WORD_LENGTH-1:0] shift_q;
  logic [WORD_LENGTH-1:0] shift_next;
  logic                   hold_valid;
  logic                   parity_q;
  logic [IDX_W-1:0]       bit_idx;
  logic [CNT_W-1:0]       baud_count;
  logic                   bit_end;
  logic                   drain;
  logic                   capture;
  logic                   load_parity;
  logic                   baud_clear;

  // The buffer is emptied when idle with a word waiting, or at the very end
  // of a stop bit when the next frame starts straight away.
  assign drain       = hold_valid && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign capture     = Transmit && (!hold_valid || drain);
  assign load_parity = parity_bit(32'(hold_data), PARITY_EVEN);
  assign shift_next  = shift_q >> 1;
  assign baud_clear  = (state == ST_IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .count  (baud_count),
    .bit_end(bit_end)
  );

  // Holding buffer, ready flag and overrun pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      TX_Ready   <= 1'b1;
      TX_Overrun <= 1'b0;
    end else begin
      TX_Overrun <= Transmit && hold_valid && !drain;
      if (capture) begin
        hold_data  <= DATATX;
        hold_valid <= 1'b1;
        TX_Ready   <= 1'b0;
      end else if (drain) begin
        hold_valid <= 1'b0;
        TX_Ready   <= 1'b1;
      end
    end
  end

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      bit_idx       <= '0;
      SerialDataOut <= 1'b1;
      TX_Busy       <= 1'b0;
      TX_Done       <= 1'b0;
    end else begin
      TX_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          SerialDataOut <= 1'b1;
          TX_Busy       <= 1'b0;
          if (hold_valid) begin
            shift_q       <= hold_data;
            parity_q      <= load_parity;
            bit_idx       <= '0;
            SerialDataOut <= 1'b0;
            TX_Busy       <= 1'b1;
            state         <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            SerialDataOut <= shift_q[0];
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_W'(WORD_LENGTH - 1)) begin
              SerialDataOut <= parity_q;
              state         <= ST_PARITY;
            end else begin
              shift_q       <= shift_next;
              SerialDataOut <= shift_next[0];
              bit_idx       <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            SerialDataOut <= 1'b1;
            state         <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Registered pulse lands on the final clk of the stop bit.
          if (baud_count == CNT_W'(CLKS_PER_BIT - 2)) begin
            TX_Done <= 1'b1;
          end
          if (bit_end) begin
            if (hold_valid) begin
              shift_q       <= hold_data;
              parity_q      <= load_parity;
              bit_idx       <= '0;
              SerialDataOut <= 1'b0;
              state         <= ST_START;
            end else begin
              SerialDataOut <= 1'b1;
              TX_Busy       <= 1'b0;
              state         <= ST_IDLE;
            end
          end
        end
        default: begin
          SerialDataOut <= 1'b1;
          TX_Busy       <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: an even-parity and an odd-parity instance
// share stimulus; recorded outputs are compared with a frame-level model.
module tb_uart_tx_framer;

  localparam int WL   = 8;
  localparam int N    = 16;
  localparam int F    = (WL + 3) * N;
  localparam int MAXC = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       transmit;
  logic [7:0] datatx;
  logic line_e, busy_e, ready_e, done_e, ovr_e;
  logic line_o, busy_o, ready_o, done_o, ovr_o;

  int checks = 0;
  int errors = 0;

  logic rec_line_e [0:MAXC];
  logic rec_line_o [0:MAXC];
  logic rec_done_e [0:MAXC];
  logic rec_busy_e [0:MAXC];
  logic rec_ready_e[0:MAXC];
  logic rec_ovr_e  [0:MAXC];

  int         sch_cyc[$];
  logic [7:0] sch_dat[$];
  int         frm_start[$];
  logic [7:0] frm_dat[$];

  always #5 clk = ~clk;

  uart_tx_framer #(.WORD_LENGTH(WL), .CLKS_PER_BIT(N), .PARITY_EVEN(1'b1)) dut_even (
    .clk(clk), .reset(reset), .DATATX(datatx), .Transmit(transmit),
    .SerialDataOut(line_e), .TX_Busy(busy_e), .TX_Ready(ready_e),
    .TX_Done(done_e), .TX_Overrun(ovr_e));

  uart_tx_framer #(.WORD_LENGTH(WL), .CLKS_PER_BIT(N), .PARITY_EVEN(1'b0)) dut_odd (
    .clk(clk), .reset(reset), .DATATX(datatx), .Transmit(transmit),
    .SerialDataOut(line_o), .TX_Busy(busy_o), .TX_Ready(ready_o),
    .TX_Done(done_o), .TX_Overrun(ovr_o));

  // ---------------- reference model ----------------
  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int j = 0; j < 8; j++) if (d[j]) n++;
    return n;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int b, input bit even);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return even ? ((ones(d) % 2) == 1) : ((ones(d) % 2) == 0);
    return 1'b1;
  endfunction

  function automatic logic exp_line(input int cyc, input bit even);
    for (int f = 0; f < frm_start.size(); f++)
      if (cyc >= frm_start[f] && cyc < frm_start[f] + F)
        return frame_bit(frm_dat[f], (cyc - frm_start[f]) / N, even);
    return 1'b1;
  endfunction

  function automatic logic exp_done(input int cyc);
    for (int f = 0; f < frm_start.size(); f++)
      if (cyc == frm_start[f] + F - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_busy(input int cyc);
    for (int f = 0; f < frm_start.size(); f++)
      if (cyc >= frm_start[f] && cyc < frm_start[f] + F) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus / recording ----------------
  // Cycle 0 is "now" (#1 after an edge); cycle i is sampled #1 after the
  // i-th following edge. A Transmit scheduled at cycle s is accepted at edge s+1.
  task automatic run(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        rec_line_e[i]  = line_e;
        rec_line_o[i]  = line_o;
        rec_done_e[i]  = done_e;
        rec_busy_e[i]  = busy_e;
        rec_ready_e[i] = ready_e;
        rec_ovr_e[i]   = ovr_e;
      end
      if (sch_cyc.size() > 0 && sch_cyc[0] == i) begin
        transmit = 1'b1;
        datatx   = sch_dat[0];
        void'(sch_cyc.pop_front());
        void'(sch_dat.pop_front());
      end else begin
        transmit = 1'b0;
        datatx   = 8'($urandom);
      end
    end
    transmit = 1'b0;
  endtask

  task automatic clear_model();
    sch_cyc.delete(); sch_dat.delete();
    frm_start.delete(); frm_dat.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; transmit = 1'b0; datatx = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (line_e !== 1'b1)  begin errors++; $display("FAIL reset_line got=%b want=1", line_e); end
    checks++; if (line_o !== 1'b1)  begin errors++; $display("FAIL reset_line_odd got=%b want=1", line_o); end
    checks++; if (busy_e !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b want=0", busy_e); end
    checks++; if (ready_e !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_e); end
    checks++; if (done_e !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b want=0", done_e); end
    checks++; if (ovr_e !== 1'b0)   begin errors++; $display("FAIL reset_overrun got=%b want=0", ovr_e); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (line_e !== 1'b1 || busy_e !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset line=%b busy=%b want line=1 busy=0", line_e, busy_e);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    int be, bo, bd, bb;
    for (int t = 0; t < 4; t++) begin
      w = (t == 0) ? 8'h05 : 8'($urandom);
      clear_model();
      sch_cyc.push_back(0); sch_dat.push_back(w);
      frm_start.push_back(2); frm_dat.push_back(w);
      run(F + 10);
      be = 0; bo = 0; bd = 0; bb = 0;
      for (int c = 1; c <= F + 10; c++) begin
        if (rec_line_e[c] !== exp_line(c, 1'b1)) be++;
        if (rec_line_o[c] !== exp_line(c, 1'b0)) bo++;
        if (rec_done_e[c] !== exp_done(c)) bd++;
        if (rec_busy_e[c] !== exp_busy(c)) bb++;
      end
      checks++; if (be != 0) begin errors++; $display("FAIL single_line_even word=%h bad_cycles=%0d want=0", w, be); end
      checks++; if (bo != 0) begin errors++; $display("FAIL single_line_odd word=%h bad_cycles=%0d want=0", w, bo); end
      checks++; if (bd != 0) begin errors++; $display("FAIL single_done word=%h bad_cycles=%0d want=0", w, bd); end
      checks++; if (bb != 0) begin errors++; $display("FAIL single_busy word=%h bad_cycles=%0d want=0", w, bb); end
      checks++; if (rec_done_e[F + 1] !== 1'b1) begin
        errors++; $display("FAIL single_done_at_176 got=%b want=1", rec_done_e[F + 1]);
      end
      checks++; if (rec_ready_e[1] !== 1'b0 || rec_ready_e[2] !== 1'b1) begin
        errors++; $display("FAIL single_ready got=%b%b want=01", rec_ready_e[1], rec_ready_e[2]);
      end
    end
  endtask

  // Receiver-style mid-bit sampling of the line.
  task automatic test_loopback();
    logic [7:0] w, rx;
    logic       par, stp, perr;
    for (int t = 0; t < 2; t++) begin
      w = (t == 0) ? 8'hA5 : 8'($urandom);
      clear_model();
      sch_cyc.push_back(0); sch_dat.push_back(w);
      run(F + 10);
      for (int b = 0; b < 8; b++) rx[b] = rec_line_e[2 + (b + 1) * N + N / 2];
      par  = rec_line_e[2 + 9 * N + N / 2];
      stp  = rec_line_e[2 + 10 * N + N / 2];
      perr = ((ones(rx) + (par ? 1 : 0)) % 2) != 0;
      checks++; if (rx !== w)     begin errors++; $display("FAIL loopback_data got=%h want=%h", rx, w); end
      checks++; if (perr !== 1'b0) begin errors++; $display("FAIL loopback_parity_error got=%b want=0", perr); end
      checks++; if (stp !== 1'b1)  begin errors++; $display("FAIL loopback_stop got=%b want=1", stp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1, w2;
    int s2, be, bo, bd, bb, bv;
    for (int t = 0; t < 3; t++) begin
      w1 = (t == 0) ? 8'hA5 : 8'($urandom);
      w2 = (t == 0) ? 8'h3C : 8'($urandom);
      s2 = (t == 0) ? 40 : int'($urandom_range(5, 150));
      clear_model();
      sch_cyc.push_back(0);  sch_dat.push_back(w1);
      sch_cyc.push_back(s2); sch_dat.push_back(w2);
      frm_start.push_back(2);     frm_dat.push_back(w1);
      frm_start.push_back(2 + F); frm_dat.push_back(w2);
      run(2 * F + 10);
      be = 0; bo = 0; bd = 0; bb = 0; bv = 0;
      for (int c = 1; c <= 2 * F + 10; c++) begin
        if (rec_line_e[c] !== exp_line(c, 1'b1)) be++;
        if (rec_line_o[c] !== exp_line(c, 1'b0)) bo++;
        if (rec_done_e[c] !== exp_done(c)) bd++;
        if (rec_busy_e[c] !== exp_busy(c)) bb++;
        if (rec_ovr_e[c] !== 1'b0) bv++;
      end
      checks++; if (be != 0) begin errors++; $display("FAIL b2b_line_even bad_cycles=%0d want=0", be); end
      checks++; if (bo != 0) begin errors++; $display("FAIL b2b_line_odd bad_cycles=%0d want=0", bo); end
      checks++; if (bd != 0) begin errors++; $display("FAIL b2b_done bad_cycles=%0d want=0", bd); end
      checks++; if (bb != 0) begin errors++; $display("FAIL b2b_busy bad_cycles=%0d want=0", bb); end
      checks++; if (bv != 0) begin errors++; $display("FAIL b2b_no_overrun pulses=%0d want=0", bv); end
      checks++; if (rec_ready_e[s2] !== 1'b1 || rec_ready_e[s2 + 1] !== 1'b0 ||
                    rec_ready_e[F + 1] !== 1'b0 || rec_ready_e[F + 2] !== 1'b1) begin
        errors++; $display("FAIL b2b_ready got=%b%b%b%b want=1001", rec_ready_e[s2],
                           rec_ready_e[s2 + 1], rec_ready_e[F + 1], rec_ready_e[F + 2]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] w1, w2, w3;
    int s2, s3, be, bv;
    for (int t = 0; t < 3; t++) begin
      w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
      s2 = int'($urandom_range(5, 60));
      s3 = int'($urandom_range(s2 + 1, 150));
      clear_model();
      sch_cyc.push_back(0);  sch_dat.push_back(w1);
      sch_cyc.push_back(s2); sch_dat.push_back(w2);
      sch_cyc.push_back(s3); sch_dat.push_back(w3);
      frm_start.push_back(2);     frm_dat.push_back(w1);
      frm_start.push_back(2 + F); frm_dat.push_back(w2);
      run(2 * F + 10);
      be = 0; bv = 0;
      for (int c = 1; c <= 2 * F + 10; c++) begin
        if (rec_line_e[c] !== exp_line(c, 1'b1)) be++;
        if (rec_ovr_e[c] !== ((c == s3 + 1) ? 1'b1 : 1'b0)) bv++;
      end
      checks++; if (be != 0) begin errors++; $display("FAIL overrun_line bad_cycles=%0d want=0", be); end
      checks++; if (bv != 0) begin errors++; $display("FAIL overrun_pulse bad_cycles=%0d want=0 (pulse at %0d)", bv, s3 + 1); end
      checks++; if (rec_ready_e[s3 + 1] !== 1'b0) begin
        errors++; $display("FAIL overrun_ready got=%b want=0", rec_ready_e[s3 + 1]);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] w;
    logic       want_o, want_e;
    for (int t = 0; t < 2; t++) begin
      w      = (t == 0) ? 8'h07 : 8'h03;
      want_o = (t == 0) ? 1'b0 : 1'b1;
      want_e = ~want_o;
      clear_model();
      sch_cyc.push_back(0); sch_dat.push_back(w);
      run(F + 10);
      checks++; if (rec_line_o[2 + 9 * N + N / 2] !== want_o) begin
        errors++; $display("FAIL parity_odd word=%h got=%b want=%b", w, rec_line_o[2 + 9 * N + N / 2], want_o);
      end
      checks++; if (rec_line_e[2 + 9 * N + N / 2] !== want_e) begin
        errors++; $display("FAIL parity_even word=%h got=%b want=%b", w, rec_line_e[2 + 9 * N + N / 2], want_e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] w1, w2;
    int be, bo;
    w1 = 8'h00; w2 = 8'($urandom);
    clear_model();
    sch_cyc.push_back(0); sch_dat.push_back(w1);
    frm_start.push_back(2); frm_dat.push_back(w1);
    run(88);
    be = 0;
    for (int c = 1; c <= 88; c++) if (rec_line_e[c] !== exp_line(c, 1'b1)) be++;
    checks++; if (be != 0) begin errors++; $display("FAIL abort_prefix_line bad_cycles=%0d want=0", be); end
    #2 reset = 1'b1;
    #1;
    checks++; if (line_e !== 1'b1 || line_o !== 1'b1) begin
      errors++; $display("FAIL abort_line got=%b%b want=11", line_e, line_o);
    end
    checks++; if (busy_e !== 1'b0 || ready_e !== 1'b1) begin
      errors++; $display("FAIL abort_flags busy=%b ready=%b want busy=0 ready=1", busy_e, ready_e);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    sch_cyc.push_back(0); sch_dat.push_back(w2);
    frm_start.push_back(2); frm_dat.push_back(w2);
    run(F + 10);
    be = 0; bo = 0;
    for (int c = 1; c <= F + 10; c++) begin
      if (rec_line_e[c] !== exp_line(c, 1'b1)) be++;
      if (rec_done_e[c] !== exp_done(c)) bo++;
    end
    checks++; if (be != 0) begin errors++; $display("FAIL abort_next_line bad_cycles=%0d want=0", be); end
    checks++; if (bo != 0) begin errors++; $display("FAIL abort_next_done bad_cycles=%0d want=0", bo); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_loopback();
    test_back_to_back();
    test_overrun();
    test_parity();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
